// File: rtl/vrased_guard.sv
// Security monitor for CPU/DMA region access and atomic trusted-code execution.
// Optional `VRASED_GUARD_LOG_EN` adds violation cause/region/count log outputs.
module vrased_guard #(
    parameter int                        NUM_REGIONS     = 4,
    parameter logic [16*NUM_REGIONS-1:0] REGION_BASE     =
        {16'hFFDF, 16'h0140, 16'h0400, 16'h6A00},
    parameter logic [16*NUM_REGIONS-1:0] REGION_SIZE     =
        {16'h0033, 16'h001F, 16'h0C00, 16'h0040},
    parameter logic [NUM_REGIONS-1:0]    REGION_RP       = 4'b0001,
    parameter logic [NUM_REGIONS-1:0]    REGION_WP       = 4'b1111,
    parameter logic [NUM_REGIONS-1:0]    REGION_DMA_DENY = 4'b1111,
    parameter logic [15:0]               SMEM_BASE       = 16'hA000,
    parameter logic [15:0]               SMEM_SIZE       = 16'h4000,
    parameter logic [15:0]               RESET_HANDLER   = 16'h0000,
    parameter logic [7:0]                HOLD_CYCLES     = 8'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] data_addr,
    input  logic        dma_en,
    input  logic [15:0] dma_addr,
    input  logic        irq,
    output logic        reset_out
`ifdef VRASED_GUARD_LOG_EN
    ,
    output logic [3:0]  viol_cause,
    output logic [2:0]  viol_region,
    output logic [7:0]  viol_count
`endif
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD =
        (HOLD_CYCLES == 8'd0) ? 8'd0 : HOLD_CYCLES - 8'd1;
    localparam logic [15:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;

    // Upper bound in 17 bits so regions touching 16'hFFFF never wrap.
    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] b,
                                      input logic [15:0] s);
        logic [16:0] top;
        top = {1'b0, b} + {1'b0, s};
        return ({1'b0, a} >= {1'b0, b}) && ({1'b0, a} < top);
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] prev_pc_q, prev_pc_d;
    logic        reset_out_q, reset_out_d;

    logic                   pc_trusted;
    logic                   prev_trusted;
    logic [NUM_REGIONS-1:0] cpu_bad;
    logic [NUM_REGIONS-1:0] dma_bad;
    logic                   cpu_viol;
    logic                   dma_viol;
    logic                   atom_viol;
    logic                   irq_viol;
    logic                   viol;

    always_comb begin
        pc_trusted   = in_range(pc, SMEM_BASE, SMEM_SIZE);
        prev_trusted = in_range(prev_pc_q, SMEM_BASE, SMEM_SIZE);
        cpu_bad      = '0;
        dma_bad      = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (data_en && !pc_trusted &&
                in_range(data_addr, REGION_BASE[16*i +: 16],
                         REGION_SIZE[16*i +: 16])) begin
                cpu_bad[i] = data_wr ? REGION_WP[i] : REGION_RP[i];
            end
            if (dma_en && REGION_DMA_DENY[i] &&
                in_range(dma_addr, REGION_BASE[16*i +: 16],
                         REGION_SIZE[16*i +: 16])) begin
                dma_bad[i] = 1'b1;
            end
        end
        cpu_viol  = |cpu_bad;
        dma_viol  = (|dma_bad) || (dma_en && pc_trusted);
        atom_viol = (!prev_trusted && pc_trusted && pc != SMEM_BASE) ||
                    (prev_trusted && !pc_trusted && prev_pc_q != SMEM_LAST);
        irq_viol  = irq && pc_trusted;
        viol      = cpu_viol || dma_viol || atom_viol || irq_viol;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_pc_d = pc;
        unique case (state_q)
            S_RUN: begin
                if (viol) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_WAIT: begin
                if (pc == RESET_HANDLER) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = 8'd0;
            end
        endcase
        reset_out_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_RUN;
            cnt_q       <= 8'd0;
            prev_pc_q   <= RESET_HANDLER;
            reset_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_pc_q   <= prev_pc_d;
            reset_out_q <= reset_out_d;
        end
    end

    assign reset_out = reset_out_q;

`ifdef VRASED_GUARD_LOG_EN
    logic [3:0] cause_q, cause_d;
    logic [2:0] region_q, region_d;
    logic [7:0] count_q, count_d;
    logic [2:0] hit_idx;
    logic       capture;

    // Scan downward so the lowest offending index wins.
    always_comb begin
        hit_idx = 3'd0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (cpu_bad[i] || dma_bad[i]) begin
                hit_idx = 3'(i);
            end
        end
        capture  = (state_q == S_RUN) && viol;
        cause_d  = cause_q;
        region_d = region_q;
        count_d  = count_q;
        if (capture) begin
            cause_d  = {irq_viol, atom_viol, dma_viol, cpu_viol};
            region_d = hit_idx;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cause_q  <= 4'd0;
            region_q <= 3'd0;
            count_q  <= 8'd0;
        end else begin
            cause_q  <= cause_d;
            region_q <= region_d;
            count_q  <= count_d;
        end
    end

    assign viol_cause  = cause_q;
    assign viol_region = region_q;
    assign viol_count  = count_q;
`endif

endmodule

// File: tb/tb_vrased_guard.sv
// Directed self-checking bench for vrased_guard.
// Log outputs are checked only when VRASED_GUARD_LOG_EN is defined.
module tb_vrased_guard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        irq;
    logic        reset_out;
`ifdef VRASED_GUARD_LOG_EN
    logic [3:0]  viol_cause;
    logic [2:0]  viol_region;
    logic [7:0]  viol_count;
`endif

    int checks = 0;
    int errors = 0;

    vrased_guard dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc        (pc),
        .data_en   (data_en),
        .data_wr   (data_wr),
        .data_addr (data_addr),
        .dma_en    (dma_en),
        .dma_addr  (dma_addr),
        .irq       (irq),
        .reset_out (reset_out)
`ifdef VRASED_GUARD_LOG_EN
        ,
        .viol_cause  (viol_cause),
        .viol_region (viol_region),
        .viol_count  (viol_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag, input logic exp);
        chk(tag, {15'd0, reset_out}, {15'd0, exp});
    endtask

    task automatic chk_log(input string tag, input logic [3:0] c,
                           input logic [2:0] r, input logic [7:0] n);
`ifdef VRASED_GUARD_LOG_EN
        chk({tag, "_cause"}, {12'd0, viol_cause}, {12'd0, c});
        chk({tag, "_region"}, {13'd0, viol_region}, {13'd0, r});
        chk({tag, "_count"}, {8'd0, viol_count}, {8'd0, n});
`else
        if (tag.len() == 0) $display("%h %h %h", c, r, n);
`endif
    endtask

    task automatic idle();
        data_en   = 1'b0;
        data_wr   = 1'b0;
        data_addr = 16'h0000;
        dma_en    = 1'b0;
        dma_addr  = 16'h0000;
        irq       = 1'b0;
    endtask

    // Called right after the violation edge: 3 more HOLD cycles, one WAIT
    // cycle with pc already at the handler, then release.
    task automatic recover(input string tag);
        idle();
        pc = 16'h0000;
        repeat (4) begin
            tick();
            chk_rst({tag, "_hold"}, 1'b1);
        end
        tick();
        chk_rst({tag, "_rel"}, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        pc      = 16'h0000;
        idle();
        tick();
        tick();
        chk_rst("reset", 1'b0);
        chk_log("reset", 4'd0, 3'd0, 8'd0);
        reset_n = 1'b1;

        // Untrusted read of RP region 0: 4 HOLD cycles, then WAIT.
        pc        = 16'hE000;
        data_en   = 1'b1;
        data_addr = 16'h6A10;
        tick();
        chk_rst("rp_rise", 1'b1);
        idle();
        repeat (4) begin
            tick();
            chk_rst("rp_hold", 1'b1);
        end
        tick();
        chk_rst("rp_wait", 1'b1);
        pc = 16'h0000;
        tick();
        chk_rst("rp_release", 1'b0);
        chk_log("rp", 4'b0001, 3'd0, 8'd1);

        // Trusted read allowed; clean exit via last SMEM word.
        pc = 16'hA000;
        tick();
        chk_rst("smem_entry", 1'b0);
        pc        = 16'hA100;
        data_en   = 1'b1;
        data_addr = 16'h6A10;
        tick();
        chk_rst("trusted_read", 1'b0);
        idle();
        pc = 16'hDFFE;
        tick();
        chk_rst("smem_last", 1'b0);
        pc = 16'hE000;
        tick();
        chk_rst("smem_exit_ok", 1'b0);

        // Untrusted write into WP region 1.
        data_en   = 1'b1;
        data_wr   = 1'b1;
        data_addr = 16'h0500;
        tick();
        chk_rst("wp_rise", 1'b1);
        recover("wp");
        chk_log("wp", 4'b0001, 3'd1, 8'd2);

        // Region 3 extends past 16'hFFFF and clamps there.
        dma_en   = 1'b1;
        dma_addr = 16'hFFFE;
        tick();
        chk_rst("dma_top", 1'b1);
        recover("dma_top");
        chk_log("dma_top", 4'b0010, 3'd3, 8'd3);

        // DMA to an open address while trusted.
        pc = 16'hA000;
        tick();
        pc = 16'hA002;
        tick();
        chk_rst("smem_step", 1'b0);
        dma_en   = 1'b1;
        dma_addr = 16'h2000;
        tick();
        chk_rst("dma_trusted", 1'b1);
        recover("dma_trusted");
        chk_log("dma_trusted", 4'b0010, 3'd0, 8'd4);

        // Entry into SMEM away from its base.
        pc = 16'hE000;
        tick();
        pc = 16'hA004;
        tick();
        chk_rst("atom_entry", 1'b1);
        recover("atom_entry");
        chk_log("atom_entry", 4'b0100, 3'd0, 8'd5);

        // Exit from SMEM away from the last word.
        pc = 16'hA000;
        tick();
        pc = 16'hA010;
        tick();
        pc = 16'hE000;
        tick();
        chk_rst("atom_exit", 1'b1);
        recover("atom_exit");
        chk_log("atom_exit", 4'b0100, 3'd0, 8'd6);

        // IRQ while trusted, then a fresh violation during HOLD.
        pc = 16'hA000;
        tick();
        pc  = 16'hA020;
        irq = 1'b1;
        tick();
        chk_rst("irq_rise", 1'b1);
        idle();
        pc       = 16'h0000;
        dma_en   = 1'b1;
        dma_addr = 16'hFFFE;
        tick();
        chk_rst("irq_hold1", 1'b1);
        idle();
        repeat (3) begin
            tick();
            chk_rst("irq_hold", 1'b1);
        end
        tick();
        chk_rst("irq_release", 1'b0);
        chk_log("irq", 4'b1000, 3'd0, 8'd7);

        // Benign traffic from untrusted code.
        pc        = 16'hE000;
        irq       = 1'b1;
        dma_en    = 1'b1;
        dma_addr  = 16'h2000;
        data_en   = 1'b1;
        data_addr = 16'h6A40;
        tick();
        chk_rst("benign", 1'b0);
        idle();

        // Synchronous reset in HOLD cycle 2.
        data_en   = 1'b1;
        data_addr = 16'h6A3F;
        tick();
        chk_rst("mid_rise", 1'b1);
        idle();
        tick();
        chk_rst("mid_hold", 1'b1);
        reset_n = 1'b0;
        tick();
        chk_rst("mid_reset", 1'b0);
        chk_log("mid_reset", 4'd0, 3'd0, 8'd0);
        reset_n = 1'b1;

        pc = 16'hA000;
        tick();
        pc = 16'hA002;
        tick();
        pc = 16'hDFFE;
        tick();
        pc = 16'hE000;
        tick();
        chk_rst("post_trusted", 1'b0);
        tick();
        chk_rst("post_idle", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
